udp_echo_client_ctrl: RTL and testbench
=======================================

Name: udp_echo_client_ctrl

Overview:
- Control block for a UDP echo client, the peer of the echo app.
- Generates a configured burst of UDP requests toward the UDP TX engine, with header then data lines.
- Consumes the echoed responses from the UDP RX engine and checks response line counts.
- Limits in-flight requests to a window and reports sent, received and error counts on completion.
- Control only; the payload and header datapath lives in a companion datapath module.

Parameters:
- REQ_CNT_W, 16, width of the request and response counters.
- LEN_W, 8, width of the request length in data lines.
- MAX_OUTSTANDING, 4, maximum number of requests sent but not yet echoed (must be >=1).
- OUTST_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- src_client_start_val  in  1  start request valid.
- client_src_start_rdy  out  1  start accepted.
- src_client_num_reqs  in  REQ_CNT_W  number of requests in the burst.
- src_client_req_len  in  LEN_W  data lines per request.
- client_dst_tx_hdr_val  out  1  TX header valid.
- dst_client_tx_hdr_rdy  in  1  TX header ready.
- client_dst_tx_data_val  out  1  TX data line valid.
- client_dst_tx_data_last  out  1  final TX line of the request.
- dst_client_tx_data_rdy  in  1  TX data ready.
- src_client_rx_hdr_val  in  1  RX header valid.
- client_src_rx_hdr_rdy  out  1  RX header ready.
- src_client_rx_data_val  in  1  RX data valid.
- src_client_rx_last  in  1  final RX line.
- client_src_rx_data_rdy  out  1  RX data ready.
- ctrl_datap_save_cfg  out  1  one-cycle pulse; datapath latches its configuration.
- ctrl_datap_incr_seq  out  1  one-cycle pulse; datapath advances the request sequence number.
- client_dst_done_val  out  1  burst complete.
- dst_client_done_rdy  in  1  completion consumed.
- client_dst_reqs_sent  out  REQ_CNT_W  number of requests sent.
- client_dst_resps_rcvd  out  REQ_CNT_W  number of responses received.
- client_dst_err_cnt  out  REQ_CNT_W  number of length mismatches plus stray responses.

Behaviour:
- Reset: all valid and ready outputs, pulses and counters go to 0; both FSMs go to IDLE. A reset mid-burst abandons the burst; nothing is flushed and no done is reported.
- Top/TX FSM states:
  - IDLE: client_src_start_rdy=1. On start handshake: latch num_reqs and req_len (a req_len of 0 is treated as 1), clear all counters, pulse ctrl_datap_save_cfg, go to TX_HDR. If num_reqs==0, go to DONE instead.
  - TX_HDR: hdr_val=1 iff sent<num_reqs and outstanding<MAX_OUTSTANDING. On hdr handshake, clear line_cnt and go to TX_DATA. If sent==num_reqs, go to WAIT.
  - TX_DATA: data_val=1; data_last=(line_cnt==req_len-1). Each handshake increments line_cnt. On the last handshake: sent++, outstanding++, pulse incr_seq, then go to TX_HDR.
  - WAIT: go to DONE when resps_rcvd==num_reqs.
  - DONE: done_val=1 and held until done_rdy; then go to IDLE. The counters stay readable until the next start.
- Valid signals, once asserted, hold until their handshake. The header is never re-issued.
- RX FSM (independent of the top FSM) never back-pressures:
  - RX_HDR: hdr_rdy=1. On handshake, go to RX_DATA and clear rx_line_cnt.
  - RX_DATA: data_rdy=1; count lines. On a last handshake, go back to RX_HDR.
- RX completion, while the top FSM is in TX_HDR, TX_DATA or WAIT:
  - If outstanding==0, err++ (stray response).
  - Otherwise resps++ and outstanding--; if the line count differs from req_len, also err++.
- RX completion in IDLE or DONE: the packet is dropped and no counter changes.
- TX last-line handshake and RX completion in the same cycle: outstanding is unchanged, sent and resps both increment.
- Counters saturate at all-ones.
- A response arriving before its request is fully sent is allowed and counts normally.

Decomposition:
- udp_echo_client_pkg holds the tx_state_e enum (IDLE, TX_HDR, TX_DATA, WAIT, DONE) and the rx_state_e enum (RX_HDR, RX_DATA).
- One sub-module: udp_echo_client_rx_chk, holding the RX FSM and line counter. It outputs a one-cycle resp_done pulse and a len_ok flag.
- The top module owns the TX FSM and all counters.

Test Plan:
- num_reqs=3, req_len=2, sink always ready, echo returned 5 cycles after each last line -> 3 headers and 6 data lines sent, last on every 2nd line, incr_seq pulsed 3 times; done with sent=3, rcvd=3, err=0.
- MAX_OUTSTANDING=4, num_reqs=8, req_len=1, no echoes until 100 cycles -> hdr_val stays low after the 4th request; then 4 echoes -> remaining 4 sent; done sent=8, rcvd=8.
- num_reqs=2, req_len=3, second echo returns 2 lines -> done with rcvd=2, err=1.
- num_reqs=0 start -> save_cfg pulses, done_val rises 1 cycle later, sent=rcvd=0; done_rdy held low 10 cycles -> done_val stays high.
- Random dst_client_tx_*_rdy backpressure at 50% with a TX last handshake coinciding with an RX last -> no dropped or duplicated lines, outstanding never exceeds 4, final counts match; an echo injected in IDLE -> all counters unchanged.
- rst asserted during TX_DATA of request 2 of 5 -> next cycle all valids=0, counters=0, start_rdy=1; a new start with num_reqs=1 completes normally.

Source files
------------

// File: rtl/udp_echo_client_pkg.sv
// Shared types for the UDP echo client control slice.
//   tx_state_e : top/TX sequencing states
//   rx_state_e : response checker states
package udp_echo_client_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_HDR,
    TX_DATA,
    WAIT,
    DONE
  } tx_state_e;

  typedef enum logic {
    RX_HDR,
    RX_DATA
  } rx_state_e;

endpackage

// File: rtl/udp_echo_client_rx_chk.sv
// Echo response checker. Accepts RX header/data lines without ever
// back-pressuring, counts data lines per packet and flags whether the
// packet length matched the configured request length.
//   clk, rst        : clock, synchronous active-high reset
//   i_req_len       : expected data lines per response (already 0->1 fixed)
//   i_hdr_val       : RX header valid        o_hdr_rdy  : RX header ready
//   i_data_val      : RX data valid          o_data_rdy : RX data ready
//   i_last          : final RX line
//   o_resp_done     : one-cycle pulse on the last-line handshake
//   o_len_ok        : line count equals i_req_len (valid with o_resp_done)
module udp_echo_client_rx_chk
  import udp_echo_client_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] i_req_len,
  input  logic             i_hdr_val,
  output logic             o_hdr_rdy,
  input  logic             i_data_val,
  input  logic             i_last,
  output logic             o_data_rdy,
  output logic             o_resp_done,
  output logic             o_len_ok
);

  rx_state_e        r_state, w_state_nxt;
  // One extra bit so an over-long packet saturates above any legal length
  // instead of wrapping back into a false match.
  logic [LEN_W:0]   r_line_cnt;
  logic [LEN_W:0]   w_cnt_inc;

  assign w_cnt_inc = (r_line_cnt == '1) ? r_line_cnt : r_line_cnt + 1'b1;
  assign o_len_ok  = (w_cnt_inc == {1'b0, i_req_len});

  always_comb begin
    w_state_nxt = r_state;
    o_hdr_rdy   = 1'b0;
    o_data_rdy  = 1'b0;
    o_resp_done = 1'b0;
    case (r_state)
      RX_HDR: begin
        o_hdr_rdy = 1'b1;
        if (i_hdr_val) w_state_nxt = RX_DATA;
      end
      RX_DATA: begin
        o_data_rdy = 1'b1;
        if (i_data_val && i_last) begin
          o_resp_done = 1'b1;
          w_state_nxt = RX_HDR;
        end
      end
      default: w_state_nxt = RX_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RX_HDR;
      r_line_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RX_HDR && i_hdr_val)
        r_line_cnt <= '0;
      else if (r_state == RX_DATA && i_data_val)
        r_line_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/udp_echo_client_ctrl.sv
// UDP echo client control. Issues a configured burst of requests (header
// then req_len data lines each) with at most MAX_OUTSTANDING un-echoed
// requests in flight, checks the echoed responses and reports
// sent/received/error counts on completion.
//   clk, rst                     : clock, synchronous active-high reset
//   src_client_start_*           : burst start handshake + num_reqs/req_len
//   client_dst_tx_hdr_*          : TX header handshake
//   client_dst_tx_data_*         : TX data line handshake (+ last)
//   src_client_rx_*              : RX echo header/data handshake (+ last)
//   ctrl_datap_save_cfg          : pulse, datapath latches its configuration
//   ctrl_datap_incr_seq          : pulse, datapath advances sequence number
//   client_dst_done_*            : completion handshake
//   client_dst_reqs_sent/resps_rcvd/err_cnt : saturating result counters
module udp_echo_client_ctrl
  import udp_echo_client_pkg::*;
#(
  parameter int REQ_CNT_W       = 16,
  parameter int LEN_W           = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUTST_W         = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_client_start_val,
  output logic                 client_src_start_rdy,
  input  logic [REQ_CNT_W-1:0] src_client_num_reqs,
  input  logic [LEN_W-1:0]     src_client_req_len,
  output logic                 client_dst_tx_hdr_val,
  input  logic                 dst_client_tx_hdr_rdy,
  output logic                 client_dst_tx_data_val,
  output logic                 client_dst_tx_data_last,
  input  logic                 dst_client_tx_data_rdy,
  input  logic                 src_client_rx_hdr_val,
  output logic                 client_src_rx_hdr_rdy,
  input  logic                 src_client_rx_data_val,
  input  logic                 src_client_rx_last,
  output logic                 client_src_rx_data_rdy,
  output logic                 ctrl_datap_save_cfg,
  output logic                 ctrl_datap_incr_seq,
  output logic                 client_dst_done_val,
  input  logic                 dst_client_done_rdy,
  output logic [REQ_CNT_W-1:0] client_dst_reqs_sent,
  output logic [REQ_CNT_W-1:0] client_dst_resps_rcvd,
  output logic [REQ_CNT_W-1:0] client_dst_err_cnt
);

  localparam logic [OUTST_W-1:0]   MAX_OUT = OUTST_W'(MAX_OUTSTANDING);
  localparam logic [REQ_CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [REQ_CNT_W-1:0] sat_inc(input logic [REQ_CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  tx_state_e            r_state, w_state_nxt;
  logic [REQ_CNT_W-1:0] r_num_reqs, r_sent, r_rcvd, r_err;
  logic [LEN_W-1:0]     r_req_len, r_line_cnt;
  logic [OUTST_W-1:0]   r_outst;

  logic w_start_hs, w_hdr_hs, w_data_hs, w_tx_done;
  logic w_rx_done, w_len_ok, w_active, w_rx_act, w_stray, w_match, w_err_inc;

  udp_echo_client_rx_chk #(.LEN_W(LEN_W)) u_rx_chk (
    .clk         (clk),
    .rst         (rst),
    .i_req_len   (r_req_len),
    .i_hdr_val   (src_client_rx_hdr_val),
    .o_hdr_rdy   (client_src_rx_hdr_rdy),
    .i_data_val  (src_client_rx_data_val),
    .i_last      (src_client_rx_last),
    .o_data_rdy  (client_src_rx_data_rdy),
    .o_resp_done (w_rx_done),
    .o_len_ok    (w_len_ok)
  );

  assign w_start_hs = src_client_start_val && client_src_start_rdy;
  assign w_hdr_hs   = client_dst_tx_hdr_val && dst_client_tx_hdr_rdy;
  assign w_data_hs  = client_dst_tx_data_val && dst_client_tx_data_rdy;
  assign w_tx_done  = w_data_hs && client_dst_tx_data_last;

  // Responses only count while a burst is running; in IDLE/DONE they drop.
  assign w_active  = (r_state == TX_HDR) || (r_state == TX_DATA) || (r_state == WAIT);
  assign w_rx_act  = w_rx_done && w_active;
  // A request completing in the same cycle covers a response that would
  // otherwise look stray, so outstanding stays level and both counts move.
  assign w_stray   = w_rx_act && (r_outst == '0) && !w_tx_done;
  assign w_match   = w_rx_act && !w_stray;
  assign w_err_inc = w_stray || (w_match && !w_len_ok);

  assign client_dst_reqs_sent  = r_sent;
  assign client_dst_resps_rcvd = r_rcvd;
  assign client_dst_err_cnt    = r_err;

  always_comb begin
    w_state_nxt             = r_state;
    client_src_start_rdy    = 1'b0;
    ctrl_datap_save_cfg     = 1'b0;
    client_dst_tx_hdr_val   = 1'b0;
    client_dst_tx_data_val  = 1'b0;
    client_dst_tx_data_last = 1'b0;
    ctrl_datap_incr_seq     = 1'b0;
    client_dst_done_val     = 1'b0;
    case (r_state)
      IDLE: begin
        client_src_start_rdy = 1'b1;
        if (src_client_start_val) begin
          ctrl_datap_save_cfg = 1'b1;
          w_state_nxt = (src_client_num_reqs == '0) ? DONE : TX_HDR;
        end
      end
      TX_HDR: begin
        if (r_sent == r_num_reqs) begin
          w_state_nxt = WAIT;
        end else begin
          // Outstanding can only fall while parked here, so once raised
          // the header valid holds until accepted.
          client_dst_tx_hdr_val = (r_outst < MAX_OUT);
          if (client_dst_tx_hdr_val && dst_client_tx_hdr_rdy) w_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        client_dst_tx_data_val  = 1'b1;
        client_dst_tx_data_last = (r_line_cnt == r_req_len - 1'b1);
        if (dst_client_tx_data_rdy && client_dst_tx_data_last) begin
          ctrl_datap_incr_seq = 1'b1;
          w_state_nxt         = TX_HDR;
        end
      end
      WAIT: begin
        if (r_rcvd == r_num_reqs) w_state_nxt = DONE;
      end
      DONE: begin
        client_dst_done_val = 1'b1;
        if (dst_client_done_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_num_reqs <= '0;
      r_req_len  <= '0;
      r_line_cnt <= '0;
      r_sent     <= '0;
      r_rcvd     <= '0;
      r_err      <= '0;
      r_outst    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_hs) begin
        r_num_reqs <= src_client_num_reqs;
        r_req_len  <= (src_client_req_len == '0) ? LEN_W'(1) : src_client_req_len;
        r_line_cnt <= '0;
        r_sent     <= '0;
        r_rcvd     <= '0;
        r_err      <= '0;
        r_outst    <= '0;
      end else begin
        if (w_hdr_hs)       r_line_cnt <= '0;
        else if (w_data_hs) r_line_cnt <= r_line_cnt + 1'b1;
        if (w_tx_done) r_sent <= sat_inc(r_sent);
        if (w_match)   r_rcvd <= sat_inc(r_rcvd);
        if (w_err_inc) r_err  <= sat_inc(r_err);
        if (w_tx_done && !w_match)      r_outst <= r_outst + 1'b1;
        else if (w_match && !w_tx_done) r_outst <= r_outst - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_udp_echo_client_ctrl.sv
// Bench for udp_echo_client_ctrl: directed bursts with a transaction-level
// reference model, a TX sink with optional random back-pressure and an
// echo responder replaying each request after a delay.
module tb_udp_echo_client_ctrl;
  localparam int RW = 16;
  localparam int LW = 8;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          src_client_start_val, client_src_start_rdy;
  logic [RW-1:0] src_client_num_reqs;
  logic [LW-1:0] src_client_req_len;
  logic          client_dst_tx_hdr_val, dst_client_tx_hdr_rdy;
  logic          client_dst_tx_data_val, client_dst_tx_data_last, dst_client_tx_data_rdy;
  logic          src_client_rx_hdr_val, client_src_rx_hdr_rdy;
  logic          src_client_rx_data_val, src_client_rx_last, client_src_rx_data_rdy;
  logic          ctrl_datap_save_cfg, ctrl_datap_incr_seq;
  logic          client_dst_done_val, dst_client_done_rdy;
  logic [RW-1:0] client_dst_reqs_sent, client_dst_resps_rcvd, client_dst_err_cnt;

  udp_echo_client_ctrl #(.REQ_CNT_W(RW), .LEN_W(LW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .src_client_start_val(src_client_start_val), .client_src_start_rdy(client_src_start_rdy),
    .src_client_num_reqs(src_client_num_reqs), .src_client_req_len(src_client_req_len),
    .client_dst_tx_hdr_val(client_dst_tx_hdr_val), .dst_client_tx_hdr_rdy(dst_client_tx_hdr_rdy),
    .client_dst_tx_data_val(client_dst_tx_data_val), .client_dst_tx_data_last(client_dst_tx_data_last),
    .dst_client_tx_data_rdy(dst_client_tx_data_rdy),
    .src_client_rx_hdr_val(src_client_rx_hdr_val), .client_src_rx_hdr_rdy(client_src_rx_hdr_rdy),
    .src_client_rx_data_val(src_client_rx_data_val), .src_client_rx_last(src_client_rx_last),
    .client_src_rx_data_rdy(client_src_rx_data_rdy),
    .ctrl_datap_save_cfg(ctrl_datap_save_cfg), .ctrl_datap_incr_seq(ctrl_datap_incr_seq),
    .client_dst_done_val(client_dst_done_val), .dst_client_done_rdy(dst_client_done_rdy),
    .client_dst_reqs_sent(client_dst_reqs_sent), .client_dst_resps_rcvd(client_dst_resps_rcvd),
    .client_dst_err_cnt(client_dst_err_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model / monitor state ----------------
  typedef struct { int due; int len; bit sync; } echo_t;
  echo_t eq[$];
  echo_t rsp_e;

  int  cyc = 0;
  bit  m_active = 0;
  int  m_num, m_len, m_sent, m_rcvd, m_err, m_out, m_line, rx_lines, tx_idx;
  int  n_hdr = 0, n_line = 0, n_last = 0, n_seq = 0, n_save = 0, n_coinc = 0, max_out = 0;
  bit  tx_last, rx_done, matched;
  bit  p_hdr_stall = 0, p_data_stall = 0, p_done_stall = 0;

  // stimulus knobs
  bit echo_en, echo_hold, echo_rand, rand_bp;
  int echo_dly, short_idx, short_len, sync_idx;

  // Model sampled 1 time unit before each rising edge; inputs change on
  // the falling edge, so every handshake seen here is the one the DUT takes.
  initial forever begin
    @(negedge clk); #4;
    cyc++;
    if (rst) begin
      m_active = 0; m_sent = 0; m_rcvd = 0; m_err = 0; m_out = 0; m_line = 0;
      eq.delete();
      p_hdr_stall = 0; p_data_stall = 0; p_done_stall = 0;
    end else begin
      if (p_hdr_stall)  chk("hdr_val_hold",  client_dst_tx_hdr_val, 1);
      if (p_data_stall) chk("data_val_hold", client_dst_tx_data_val, 1);
      if (p_done_stall) chk("done_val_hold", client_dst_done_val, 1);
      if (ctrl_datap_save_cfg) n_save++;
      if (ctrl_datap_incr_seq) n_seq++;
      if (client_dst_done_val) m_active = 0;
      tx_last = 0;
      if (src_client_start_val && client_src_start_rdy) begin
        m_active = 1; m_num = src_client_num_reqs;
        m_len = (src_client_req_len == 0) ? 1 : src_client_req_len;
        m_sent = 0; m_rcvd = 0; m_err = 0; m_out = 0; tx_idx = 0;
      end
      if (client_dst_tx_hdr_val && dst_client_tx_hdr_rdy) begin
        n_hdr++; m_line = 0;
        chk("hdr_window", m_out < MO, 1);
        chk("hdr_needed", m_sent < m_num, 1);
      end
      if (client_dst_tx_data_val && dst_client_tx_data_rdy) begin
        n_line++;
        chk("data_last", client_dst_tx_data_last, m_line == m_len - 1);
        m_line++;
        if (client_dst_tx_data_last) begin n_last++; tx_last = 1; end
      end
      if (src_client_rx_hdr_val && client_src_rx_hdr_rdy) rx_lines = 0;
      rx_done = 0;
      if (src_client_rx_data_val && client_src_rx_data_rdy) begin
        rx_lines++;
        rx_done = src_client_rx_last;
      end
      if (tx_last) begin
        m_sent++;
        if (echo_en)
          eq.push_back('{cyc + echo_dly + (echo_rand ? int'($urandom_range(0, 6)) : 0),
                         (tx_idx == short_idx) ? short_len : m_len, tx_idx == sync_idx});
        tx_idx++;
      end
      if (tx_last && rx_done) n_coinc++;
      matched = 0;
      if (rx_done && m_active) begin
        if (m_out == 0 && !tx_last) m_err++;
        else begin
          matched = 1; m_rcvd++;
          if (rx_lines != m_len) m_err++;
        end
      end
      if (tx_last && !matched) m_out++;
      else if (matched && !tx_last) m_out--;
      if (m_out > max_out) max_out = m_out;
      p_hdr_stall  = client_dst_tx_hdr_val && !dst_client_tx_hdr_rdy;
      p_data_stall = client_dst_tx_data_val && !dst_client_tx_data_rdy;
      p_done_stall = client_dst_done_val && !dst_client_done_rdy;
    end
  end

  // ---------------- TX sink ----------------
  initial begin
    dst_client_tx_hdr_rdy = 1; dst_client_tx_data_rdy = 1;
    forever begin
      @(negedge clk);
      dst_client_tx_hdr_rdy  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dst_client_tx_data_rdy = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- echo responder ----------------
  task automatic send_pkt(input echo_t e);
    int g;
    src_client_rx_hdr_val = 1;
    g = 0;
    while (!client_src_rx_hdr_rdy && g < 50) begin @(negedge clk); g++; end
    chk("rx_hdr_rdy_wait", g < 50, 1);
    @(negedge clk);
    src_client_rx_hdr_val = 0;
    for (int i = 0; i < e.len; i++) begin
      src_client_rx_last = (i == e.len - 1);
      if (e.sync && i == e.len - 1) begin
        // hold the final line back until a TX last line is on the wire
        src_client_rx_data_val = 0;
        g = 0;
        while (!(client_dst_tx_data_val && client_dst_tx_data_last) && g < 200) begin
          @(negedge clk); g++;
        end
        chk("sync_wait", g < 200, 1);
      end
      src_client_rx_data_val = 1;
      g = 0;
      while (!client_src_rx_data_rdy && g < 50) begin @(negedge clk); g++; end
      chk("rx_data_rdy_wait", g < 50, 1);
      @(negedge clk);
    end
    src_client_rx_data_val = 0;
    src_client_rx_last = 0;
  endtask

  initial begin
    src_client_rx_hdr_val = 0; src_client_rx_data_val = 0; src_client_rx_last = 0;
    forever begin
      @(negedge clk);
      if (!echo_hold && eq.size() > 0 && cyc >= eq[0].due) begin
        rsp_e = eq.pop_front();
        send_pkt(rsp_e);
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic start_burst(input int n, input int l);
    int g;
    src_client_start_val = 1; src_client_num_reqs = RW'(n); src_client_req_len = LW'(l);
    g = 0;
    while (!client_src_start_rdy && g < 50) begin @(negedge clk); g++; end
    chk("start_rdy_wait", g < 50, 1);
    @(negedge clk);
    src_client_start_val = 0;
  endtask

  task automatic wait_done_ack();
    int g;
    g = 0;
    while (!client_dst_done_val && g < 5000) begin @(negedge clk); g++; end
    chk("done_wait", client_dst_done_val, 1);
    chk("model_sent", client_dst_reqs_sent, m_sent);
    chk("model_rcvd", client_dst_resps_rcvd, m_rcvd);
    chk("model_err", client_dst_err_cnt, m_err);
    dst_client_done_rdy = 1;
    @(negedge clk);
    dst_client_done_rdy = 0;
    chk("idle_after_done", client_src_start_rdy, 1);
  endtask

  int h0, l0, k0, q0, s0, c0, rl, g;

  initial begin
    rst = 1; src_client_start_val = 0; src_client_num_reqs = 0; src_client_req_len = 0;
    dst_client_done_rdy = 0;
    echo_en = 1; echo_hold = 0; echo_rand = 0; rand_bp = 0; echo_dly = 5;
    short_idx = -1; short_len = 0; sync_idx = -1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_hdr_val", client_dst_tx_hdr_val, 0);
    chk("rst_data_val", client_dst_tx_data_val, 0);
    chk("rst_done_val", client_dst_done_val, 0);
    chk("rst_save_cfg", ctrl_datap_save_cfg, 0);
    chk("rst_incr_seq", ctrl_datap_incr_seq, 0);
    chk("rst_sent", client_dst_reqs_sent, 0);
    chk("rst_rcvd", client_dst_resps_rcvd, 0);
    chk("rst_err", client_dst_err_cnt, 0);
    chk("rst_start_rdy", client_src_start_rdy, 1);
    rst = 0;
    @(negedge clk);

    // 3 requests of 2 lines, echo 5 cycles after each last line
    h0 = n_hdr; l0 = n_line; k0 = n_last; q0 = n_seq;
    start_burst(3, 2);
    wait_done_ack();
    chk("t1_hdrs", n_hdr - h0, 3);
    chk("t1_lines", n_line - l0, 6);
    chk("t1_lasts", n_last - k0, 3);
    chk("t1_incr_seq", n_seq - q0, 3);
    chk("t1_sent", client_dst_reqs_sent, 3);
    chk("t1_rcvd", client_dst_resps_rcvd, 3);
    chk("t1_err", client_dst_err_cnt, 0);

    // window limit: echoes held back for 100 cycles
    echo_hold = 1; echo_dly = 0; max_out = 0;
    start_burst(8, 1);
    repeat (100) @(negedge clk);
    chk("t2_hdr_blocked", client_dst_tx_hdr_val, 0);
    chk("t2_sent_at_window", client_dst_reqs_sent, 4);
    chk("t2_rcvd_held", client_dst_resps_rcvd, 0);
    echo_hold = 0;
    wait_done_ack();
    chk("t2_sent", client_dst_reqs_sent, 8);
    chk("t2_rcvd", client_dst_resps_rcvd, 8);
    chk("t2_max_out", max_out, 4);

    // short echo for the second request
    echo_dly = 3; short_idx = 1; short_len = 2;
    start_burst(2, 3);
    wait_done_ack();
    chk("t3_rcvd", client_dst_resps_rcvd, 2);
    chk("t3_err", client_dst_err_cnt, 1);
    short_idx = -1;

    // empty burst, completion held off for 10 cycles
    s0 = n_save;
    src_client_start_val = 1; src_client_num_reqs = 0; src_client_req_len = 4;
    #1;
    chk("t4_save_cfg", ctrl_datap_save_cfg, 1);
    chk("t4_done_not_yet", client_dst_done_val, 0);
    @(negedge clk);
    src_client_start_val = 0;
    #1;
    chk("t4_done_rise", client_dst_done_val, 1);
    chk("t4_save_once", n_save - s0, 1);
    repeat (10) @(negedge clk);
    chk("t4_done_held", client_dst_done_val, 1);
    chk("t4_sent", client_dst_reqs_sent, 0);
    chk("t4_rcvd", client_dst_resps_rcvd, 0);
    wait_done_ack();

    // RX last lands on the same edge as a TX last
    echo_dly = 0; sync_idx = 0; c0 = n_coinc;
    start_burst(2, 1);
    wait_done_ack();
    chk("t5_coincide", n_coinc - c0, 1);
    chk("t5_sent", client_dst_reqs_sent, 2);
    chk("t5_rcvd", client_dst_resps_rcvd, 2);
    chk("t5_err", client_dst_err_cnt, 0);
    sync_idx = -1;

    // random back-pressure and echo delays
    rand_bp = 1; echo_rand = 1; max_out = 0;
    rl = $urandom_range(1, 4);
    h0 = n_hdr; l0 = n_line;
    start_burst(10, rl);
    wait_done_ack();
    chk("t6_sent", client_dst_reqs_sent, 10);
    chk("t6_rcvd", client_dst_resps_rcvd, 10);
    chk("t6_err", client_dst_err_cnt, 0);
    chk("t6_hdrs", n_hdr - h0, 10);
    chk("t6_lines", n_line - l0, 10 * rl);
    chk("t6_window", max_out <= MO, 1);
    rand_bp = 0; echo_rand = 0;

    // echo arriving in IDLE is dropped
    eq.push_back('{0, 2, 1'b0});
    repeat (12) @(negedge clk);
    chk("t7_idle_sent", client_dst_reqs_sent, 10);
    chk("t7_idle_rcvd", client_dst_resps_rcvd, 10);
    chk("t7_idle_err", client_dst_err_cnt, 0);

    // reset in the middle of request 2 of 5
    echo_en = 0;
    start_burst(5, 3);
    g = 0;
    while (!(m_sent == 1 && client_dst_tx_data_val) && g < 500) begin @(negedge clk); g++; end
    chk("t8_reach_req2", g < 500, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("t8_hdr_val", client_dst_tx_hdr_val, 0);
    chk("t8_data_val", client_dst_tx_data_val, 0);
    chk("t8_done_val", client_dst_done_val, 0);
    chk("t8_sent", client_dst_reqs_sent, 0);
    chk("t8_rcvd", client_dst_resps_rcvd, 0);
    chk("t8_err", client_dst_err_cnt, 0);
    chk("t8_start_rdy", client_src_start_rdy, 1);
    @(negedge clk);
    echo_en = 1; echo_dly = 2;
    start_burst(1, 2);
    wait_done_ack();
    chk("t8_new_sent", client_dst_reqs_sent, 1);
    chk("t8_new_rcvd", client_dst_resps_rcvd, 1);
    chk("t8_new_err", client_dst_err_cnt, 0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
